mem_arbiter_mms: RTL and testbench

Parametrised single-port memory subsystem serving the instruction-fetch client and the data client of the CPU datapath. The two clients share one synchronous RAM through a round-robin-on-conflict arbiter with req/ack handshakes. It supports a selectable data-address source among N inputs, registered read outputs, write-through read-back, and out-of-range address fault detection. It replaces the fixed 16x1k dual-port memory wrapper and sits between the control unit/PC logic and the register file/immediate path.

---
 rtl/mem_arbiter_mms.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter_mms.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_mms.sv
// Purpose : shared single-port RAM for the fetch client and the data client,
//           with a round-robin-on-conflict arbiter and registered read results.
// Latency : 1 cycle; a request granted in cycle t is acked, with data, in cycle t+1.
// Backpres: the losing requester gets no ack and is served once its request wins.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   r1, a1            fetch request and word address (read-only client)
//   r2, w2            data read / write request
//   memsrc, a2_src    data-address source select and packed 16-bit sources
//   write2            data write value
//   ir                last fetched word
//   imr, memout       last data-port read value (immediate path / datapath)
//   f_ack, d_ack      access completed this cycle (fetch / data)
//   fault             the access acked this cycle had an out-of-range address
module mem_arbiter_mms #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int N_SRC  = 2,
   parameter int SEL_W  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                r1,
   input  logic [15:0]         a1,
   input  logic                r2,
   input  logic                w2,
   input  logic [SEL_W-1:0]    memsrc,
   input  logic [N_SRC*16-1:0] a2_src,
   input  logic [DATA_W-1:0]   write2,
   output logic [DATA_W-1:0]   ir,
   output logic [DATA_W-1:0]   imr,
   output logic [DATA_W-1:0]   memout,
   output logic                f_ack,
   output logic                d_ack,
   output logic                fault
);

   localparam int          DEPTH   = 1 << ADDR_W;
   // Address bits above the index must all be zero for an in-range access.
   localparam logic [15:0] HI_MASK = 16'hFFFF << ADDR_W;

   typedef enum logic {
      WIN_FETCH = 1'b0,
      WIN_DATA  = 1'b1
   } win_t;

   // Storage; deliberately not cleared by reset.
   logic [DATA_W-1:0] mem [DEPTH];

   // Registered state
   win_t              last_win_q, last_win_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              f_ack_q, f_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              fault_q, fault_d;

   // Request decode and address path
   logic              f_req, d_req, conflict;
   logic              grant_f, grant_d;
   logic [15:0]       a2;
   logic              f_in_range, d_in_range;
   logic [ADDR_W-1:0] f_idx, d_idx;
   logic [DATA_W-1:0] f_rd, d_rd;

   // ------------------------------------------------------------------
   // Data-address source select; unused select codes fall back to source 0.
   // ------------------------------------------------------------------
   always_comb begin
      a2 = a2_src[15:0];
      for (int k = 1; k < N_SRC; k++) begin
         if (int'(memsrc) == k) begin
            a2 = a2_src[16*k +: 16];
         end
      end
   end

   assign f_in_range = ((a1 & HI_MASK) == 16'h0000);
   assign d_in_range = ((a2 & HI_MASK) == 16'h0000);
   assign f_idx      = a1[ADDR_W-1:0];
   assign d_idx      = a2[ADDR_W-1:0];
   assign f_rd       = mem[f_idx];
   assign d_rd       = mem[d_idx];

   // ------------------------------------------------------------------
   // Arbitration: a lone requester always wins; on a conflict the client
   // that did not win the previous conflict gets the slot.
   // ------------------------------------------------------------------
   always_comb begin
      f_req    = r1;
      d_req    = r2 | w2;
      conflict = f_req & d_req;
      grant_f  = f_req & (~d_req | (last_win_q == WIN_DATA));
      grant_d  = d_req & ~grant_f;

      last_win_d = last_win_q;
      if (conflict) begin
         last_win_d = grant_f ? WIN_FETCH : WIN_DATA;
      end
   end

   // ------------------------------------------------------------------
   // Next-state for the result registers. An out-of-range access loads 0
   // and raises fault in its ack cycle; outputs hold between acks.
   // ------------------------------------------------------------------
   always_comb begin
      ir_d    = ir_q;
      rd_d    = rd_q;
      f_ack_d = grant_f;
      d_ack_d = grant_d;
      fault_d = (grant_f & ~f_in_range) | (grant_d & ~d_in_range);

      if (grant_f) begin
         ir_d = f_in_range ? f_rd : '0;
      end

      if (grant_d) begin
         if (!d_in_range) begin
            rd_d = '0;
         end else if (w2) begin
            // Write-through: a write (with or without r2) returns the new value.
            rd_d = write2;
         end else begin
            rd_d = d_rd;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_win_q <= WIN_FETCH;
         ir_q       <= '0;
         rd_q       <= '0;
         f_ack_q    <= 1'b0;
         d_ack_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         last_win_q <= last_win_d;
         ir_q       <= ir_d;
         rd_q       <= rd_d;
         f_ack_q    <= f_ack_d;
         d_ack_q    <= d_ack_d;
         fault_q    <= fault_d;
      end
   end

   // RAM write port; writes are suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (grant_d && w2 && d_in_range && !reset) begin
         mem[d_idx] <= write2;
      end
   end

   assign ir     = ir_q;
   assign imr    = rd_q;
   assign memout = rd_q;
   assign f_ack  = f_ack_q;
   assign d_ack  = d_ack_q;
   assign fault  = fault_q;

endmodule

// File: tb/tb_mem_arbiter_mms.sv
module tb_mem_arbiter_mms;

   logic        clk = 1'b0;
   logic        reset;
   logic        r1, r2, w2;
   logic [15:0] a1;
   logic [0:0]  memsrc;
   logic [31:0] a2_src;
   logic [15:0] write2;
   logic [15:0] ir, imr, memout;
   logic        f_ack, d_ack, fault;

   int vectors = 0;
   int miscompares = 0;

   mem_arbiter_mms #(.DATA_W(16), .ADDR_W(10), .N_SRC(2), .SEL_W(1)) dut (
      .clk    (clk),
      .reset  (reset),
      .r1     (r1),
      .a1     (a1),
      .r2     (r2),
      .w2     (w2),
      .memsrc (memsrc),
      .a2_src (a2_src),
      .write2 (write2),
      .ir     (ir),
      .imr    (imr),
      .memout (memout),
      .f_ack  (f_ack),
      .d_ack  (d_ack),
      .fault  (fault)
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single-cycle data write to an address through source 0.
   task automatic do_write(input logic [15:0] addr, input logic [15:0] val);
      w2 = 1'b1; memsrc = 1'b0; a2_src = {16'h0000, addr}; write2 = val;
      tick();
      chk("wr_d_ack", d_ack, 1);
      w2 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      r1 = 0; r2 = 0; w2 = 0; a1 = 0; memsrc = 0; a2_src = 0; write2 = 0;
      tick();
      tick();
      chk("rst_ir", ir, 0);
      chk("rst_memout", memout, 0);
      chk("rst_imr", imr, 0);
      chk("rst_f_ack", f_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_fault", fault, 0);
      reset = 1'b0;
      tick();

      // Write BEEF to 0x0005, then fetch it back.
      w2 = 1; memsrc = 0; a2_src = {16'h0000, 16'h0005}; write2 = 16'hBEEF;
      tick();
      chk("w5_d_ack", d_ack, 1);
      chk("w5_f_ack", f_ack, 0);
      chk("w5_memout", memout, 16'hBEEF);
      chk("w5_imr", imr, 16'hBEEF);
      chk("w5_fault", fault, 0);
      w2 = 0;
      r1 = 1; a1 = 16'h0005;
      tick();
      chk("f5_f_ack", f_ack, 1);
      chk("f5_d_ack", d_ack, 0);
      chk("f5_ir", ir, 16'hBEEF);
      r1 = 0;
      tick();
      chk("idle_f_ack", f_ack, 0);
      chk("hold_ir", ir, 16'hBEEF);
      chk("hold_memout", memout, 16'hBEEF);

      // Preload.
      do_write(16'h0010, 16'h1111);
      do_write(16'h0020, 16'h2222);
      do_write(16'h03FF, 16'h3FFF);
      do_write(16'h0000, 16'h0A0A);

      // Sustained conflict: data wins first (last_win resets to FETCH).
      r1 = 1; a1 = 16'h0010;
      r2 = 1; memsrc = 0; a2_src = {16'h0000, 16'h0020};
      tick();
      chk("c1_d_ack", d_ack, 1);
      chk("c1_f_ack", f_ack, 0);
      chk("c1_memout", memout, 16'h2222);
      tick();
      chk("c2_d_ack", d_ack, 0);
      chk("c2_f_ack", f_ack, 1);
      chk("c2_ir", ir, 16'h1111);
      tick();
      chk("c3_d_ack", d_ack, 1);
      chk("c3_f_ack", f_ack, 0);
      chk("c3_memout", memout, 16'h2222);
      tick();
      chk("c4_d_ack", d_ack, 0);
      chk("c4_f_ack", f_ack, 1);
      chk("c4_ir", ir, 16'h1111);
      r1 = 0; r2 = 0;

      // Source mux and top-of-memory.
      r2 = 1; memsrc = 1; a2_src = {16'h03FF, 16'h0000};
      tick();
      chk("src1_d_ack", d_ack, 1);
      chk("src1_memout", memout, 16'h3FFF);
      chk("src1_fault", fault, 0);
      memsrc = 0;
      tick();
      chk("src0_memout", memout, 16'h0A0A);
      r2 = 0;

      // Out-of-range write: fault, result 0, memory untouched.
      w2 = 1; memsrc = 0; a2_src = {16'h0000, 16'h0400}; write2 = 16'hDEAD;
      tick();
      chk("oor_w_d_ack", d_ack, 1);
      chk("oor_w_fault", fault, 1);
      chk("oor_w_memout", memout, 0);
      w2 = 0;
      r2 = 1; a2_src = {16'h0000, 16'h0000};
      tick();
      chk("rd0_memout", memout, 16'h0A0A);
      chk("rd0_fault", fault, 0);
      r2 = 0;

      // Out-of-range fetch must not alias onto 0x0005.
      r1 = 1; a1 = 16'h8005;
      tick();
      chk("oor_f_f_ack", f_ack, 1);
      chk("oor_f_fault", fault, 1);
      chk("oor_f_ir", ir, 0);
      r1 = 0;
      tick();
      chk("idle_fault", fault, 0);

      // Write-through with r2 and w2 together, then read back.
      r2 = 1; w2 = 1; a2_src = {16'h0000, 16'h0030}; write2 = 16'h3333;
      tick();
      chk("wt_memout", memout, 16'h3333);
      w2 = 0;
      tick();
      chk("wt_rb_memout", memout, 16'h3333);
      r2 = 0;
      r1 = 1; a1 = 16'h0005;
      tick();
      chk("f5b_ir", ir, 16'hBEEF);
      r1 = 0;

      // Reset in the ack cycle of a faulting access.
      r2 = 1; a2_src = {16'h0000, 16'h0500};
      tick();
      chk("pre_rst_d_ack", d_ack, 1);
      chk("pre_rst_fault", fault, 1);
      reset = 1'b1;
      #1;
      chk("arst_d_ack", d_ack, 0);
      chk("arst_fault", fault, 0);
      chk("arst_ir", ir, 0);
      chk("arst_memout", memout, 0);
      r2 = 0;
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_idle", d_ack, 0);

      // First conflict after reset goes to data.
      r1 = 1; a1 = 16'h0010;
      r2 = 1; a2_src = {16'h0000, 16'h0020};
      tick();
      chk("pr_c1_d_ack", d_ack, 1);
      chk("pr_c1_f_ack", f_ack, 0);
      chk("pr_c1_memout", memout, 16'h2222);
      tick();
      chk("pr_c2_f_ack", f_ack, 1);
      chk("pr_c2_ir", ir, 16'h1111);
      r1 = 0; r2 = 0;

      // Streaming fetch over 8 sequential addresses.
      for (int i = 0; i < 8; i++) begin
         do_write(16'h0100 + 16'(i), 16'hA000 + 16'(i));
      end
      r1 = 1; a1 = 16'h0100;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("stream%0d_f_ack", i), f_ack, 1);
         chk($sformatf("stream%0d_ir", i), ir, 16'hA000 + 16'(i));
         a1 = 16'h0101 + 16'(i);
      end
      r1 = 0;
      tick();
      chk("stream_end_f_ack", f_ack, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
